// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first, WIDTH+2 cycles per operation.
// Define SERIAL_ADD_OVF_EN to compile in signed-overflow detection; otherwise ovf is tied to 0.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             sbit, cnext;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Operands shift right each step so the active bit is always at position 0.
  assign sbit  = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign cnext = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = cnext;
        acc_d   = {sbit, acc_q[WIDTH-1:1]};
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Final bit: publish the result on the same edge that enters DONE.
          state_d = DONE;
          idx_d   = '0;
          sum_d   = {sbit, acc_q[WIDTH-1:1]};
          cout_d  = cnext;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ cnext;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    acc_q <= acc_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed table, lockout/reset sequences, random ops.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk, rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mode 0: plain op, 1: foreign start pulsed at edge k+3, 2: reset at edge k+4
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo, input int mode);
    int dones;
    a = ta; b = tbv; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("busy_at_k", busy, 1);
    chk("done_at_k", done, 0);
    for (int i = 1; i <= W; i++) begin
      if (mode == 1 && i == 3) begin a = 8'hAA; b = 8'h55; start = 1'b1; end
      if (mode == 2 && i == 4) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 2 && i == 4) begin
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        dones = 0;
        repeat (12) begin @(posedge clk); #1; if (done) dones++; end
        chk("rst_no_done", dones, 0);
        chk("rst_idle_busy", busy, 0);
        return;
      end
      if (i < W) begin
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_sum_hold", sum, prev_sum);
        chk("run_cout_hold", cout, prev_cout);
        chk("run_ovf_hold", ovf, prev_ovf);
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo & OVF_EN);
      end
    end
    @(posedge clk); #1;
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_sum", sum, es);
    prev_sum = es; prev_cout = ec; prev_ovf = eo & OVF_EN;
    if (mode == 1) begin
      dones = 0;
      repeat (12) begin @(posedge clk); #1; if (done || busy) dones++; end
      chk("lockout_no_second", dones, 0);
      chk("lockout_sum", sum, es);
    end
  endtask

  initial begin
    logic [W:0]   s9;
    logic [W-1:0] ra, rb, es;
    logic         rc, eo;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    rst = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

    // Table vectors issued back to back at the minimum interval.
    for (int i = 0; i < 7; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].ov, 0);

    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1);
    do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 2);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      s9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      es = s9[W-1:0];
      eo = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
      do_op(ra, rb, rc, es, s9[W], eo, 0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin an addition.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- busy  output  1  operation in progress; high in RUN and DONE.
- done  output  1  one-cycle result-valid strobe.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry-out.
- ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-004 The block SHALL sequence a single 1-bit full-adder cell bit-serially, LSB first: sum bit = a^b^c, carry = majority(a,b,c).
REQ-005 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in 2 bits.
REQ-006 IDLE -> RUN SHALL occur on the edge where start=1 is sampled.
- a, b and cin are latched on that edge.
- The bit index is set to 0.
REQ-007 In RUN, each edge SHALL process bit[idx], update the carry register and increment idx.
REQ-008 RUN -> DONE SHALL occur on the edge processing bit WIDTH-1.
- sum and cout are loaded on that same edge.
REQ-009 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-010 Latency: if start is sampled at edge k, done SHALL be 1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-011 busy SHALL be 1 from edge k to edge k+WIDTH+1; done SHALL be 1 only in DONE.
REQ-012 start SHALL be ignored in RUN and DONE, with no queuing.
- Operand or cin changes after edge k SHALL NOT affect the result.
REQ-013 sum, cout and ovf SHALL hold their previous values throughout RUN and change only on the edge entering DONE.
- They hold until the next completed operation.
REQ-014 Arithmetic SHALL be unsigned modulo 2^WIDTH; cout is carry out of bit WIDTH-1.
REQ-015 A back-to-back start is accepted in IDLE on the edge immediately after DONE.
- Minimum issue interval is WIDTH+2 cycles.

Reset
REQ-016 rst=1 at a clock edge SHALL force state IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, busy=0 and done=0.
REQ-017 rst SHALL take priority over start and over any in-flight operation.
- An aborted operation SHALL produce no done pulse and SHALL leave sum/cout at 0.

Configuration
REQ-018 Macro SERIAL_ADD_OVF_EN, when defined, SHALL compile in signed-overflow detection.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- ovf is loaded with sum per REQ-013.
REQ-019 Without SERIAL_ADD_OVF_EN, the ovf port SHALL remain and be tied to constant 0, with no detection logic.

Verification
REQ-020 Bench SHALL cover, with WIDTH=8:
- Operands and timing: a=8'h0F, b=8'h01, cin=0, start at edge k -> sum=8'h10, cout=0, done high only between edges k+8 and k+9, busy low after k+9.
- Full wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; with cin=1 -> sum=8'h01, cout=1.
- Carry-in only: a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Busy lockout: start pulsed at edge k+3 with a=8'hAA, b=8'h55 during a 8'h0F+8'h01 run -> single done, sum=8'h10, no second operation.
- Reset mid-operation: rst=1 at edge k+4 -> busy=0, sum=0, cout=0, no done pulse; a new start afterward completes normally.
- Overflow, macro defined: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1; a=8'hFF, b=8'h01 -> ovf=0. Macro undefined -> ovf=0 in both cases.
